axi4lite_blockmem_ctrl: RTL

- AXI4-Lite slave that turns register-style bus accesses into single-word accesses on one port of the dual-port block memory wrapper.
- Sits directly upstream of the memory and drives one port (ena/wea/addra/dina, consumes douta).
- The other memory port stays free for the fabric-side client.
- Serialises reads and writes onto the single memory port with fair arbitration, and flags out-of-range accesses with SLVERR.

---
 rtl/axi4lite_blockmem_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/axi4lite_blockmem_ctrl.sv
// AXI4-Lite slave driving one port of a dual-port block memory.
// Reads and writes are serialised onto the port with alternating priority; out-of-range accesses get SLVERR.
module axi4lite_blockmem_ctrl #(
    parameter int G_MEMWIDTH       = 32,
    parameter int G_MEMDEPTH       = 1024,
    parameter int G_AXI_ADDR_WIDTH = 16,
    localparam int G_ADDRWIDTH     = $clog2(G_MEMDEPTH),
    localparam int G_WEWIDTH       = 4
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [G_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [G_MEMWIDTH-1:0]       s_axi_wdata,
    input  logic [G_WEWIDTH-1:0]        s_axi_wstrb,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    input  logic [G_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    output logic [G_MEMWIDTH-1:0]       s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    output logic                        mem_en,
    output logic [G_WEWIDTH-1:0]        mem_we,
    output logic [G_ADDRWIDTH-1:0]      mem_addr,
    output logic [G_MEMWIDTH-1:0]       mem_din,
    input  logic [G_MEMWIDTH-1:0]       mem_dout
);

    if (G_MEMWIDTH != 32) begin : g_chk_width
        $error("axi4lite_blockmem_ctrl: only G_MEMWIDTH = 32 is supported");
    end
    if (G_AXI_ADDR_WIDTH < G_ADDRWIDTH + 2) begin : g_chk_addr
        $error("axi4lite_blockmem_ctrl: G_AXI_ADDR_WIDTH too small for G_MEMDEPTH");
    end

    localparam int LIMIT_W = G_AXI_ADDR_WIDTH + 1;
    localparam logic [LIMIT_W-1:0] BYTE_LIMIT = LIMIT_W'(G_MEMDEPTH * 4);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_WR, S_WRESP, S_RD, S_RWAIT, S_RRESP} state_e;
    typedef enum logic {GNT_READ, GNT_WRITE} grant_e;

    state_e                        state_q;
    grant_e                        last_grant_q;
    logic                          aw_full_q, aw_full_d, w_full_q, w_full_d, ar_full_q, ar_full_d;
    logic [G_AXI_ADDR_WIDTH-1:0]   aw_addr_q, ar_addr_q;
    logic [G_MEMWIDTH-1:0]         wdata_q, rdata_q, mem_din_q;
    logic [G_WEWIDTH-1:0]          wstrb_q, mem_we_q;
    logic [G_ADDRWIDTH-1:0]        mem_addr_q;
    logic                          awready_q, wready_q, arready_q, bvalid_q, rvalid_q, mem_en_q;
    logic [1:0]                    bresp_q, rresp_q;
    logic                          wr_oor_q, rd_oor_q;

    logic                          aw_hs, w_hs, ar_hs, wr_pair, rd_avail, grant_wr, grant_rd;
    logic [G_AXI_ADDR_WIDTH-1:0]   eff_awaddr, eff_araddr;
    logic [G_MEMWIDTH-1:0]         eff_wdata;
    logic [G_WEWIDTH-1:0]          eff_wstrb;
    logic                          eff_aw_oor, eff_ar_oor;

    function automatic logic out_of_range(input logic [G_AXI_ADDR_WIDTH-1:0] a);
        return {1'b0, a} >= BYTE_LIMIT;
    endfunction

    assign aw_hs = s_axi_awvalid & awready_q;
    assign w_hs  = s_axi_wvalid & wready_q;
    assign ar_hs = s_axi_arvalid & arready_q;

    // Requests handshaken this cycle are visible to the arbiter directly, saving a cycle of latency.
    assign eff_awaddr = aw_full_q ? aw_addr_q : s_axi_awaddr;
    assign eff_wdata  = w_full_q ? wdata_q : s_axi_wdata;
    assign eff_wstrb  = w_full_q ? wstrb_q : s_axi_wstrb;
    assign eff_araddr = ar_full_q ? ar_addr_q : s_axi_araddr;
    assign eff_aw_oor = out_of_range(eff_awaddr);
    assign eff_ar_oor = out_of_range(eff_araddr);

    assign wr_pair  = (aw_full_q | aw_hs) & (w_full_q | w_hs);
    assign rd_avail = ar_full_q | ar_hs;
    assign grant_wr = (state_q == S_IDLE) & wr_pair & (~rd_avail | (last_grant_q == GNT_READ));
    assign grant_rd = (state_q == S_IDLE) & rd_avail & (~wr_pair | (last_grant_q == GNT_WRITE));

    always_comb begin
        aw_full_d = aw_full_q | aw_hs;
        w_full_d  = w_full_q | w_hs;
        ar_full_d = ar_full_q | ar_hs;
        if (state_q == S_WR) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end
        if (state_q == S_RRESP && s_axi_rready) ar_full_d = 1'b0;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            ar_full_q <= 1'b0;
            aw_addr_q <= '0;
            ar_addr_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            ar_full_q <= ar_full_d;
            if (aw_hs) aw_addr_q <= s_axi_awaddr;
            if (ar_hs) ar_addr_q <= s_axi_araddr;
            if (w_hs) begin
                wdata_q <= s_axi_wdata;
                wstrb_q <= s_axi_wstrb;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= S_IDLE;
            last_grant_q <= GNT_READ;
            awready_q    <= 1'b0;
            wready_q     <= 1'b0;
            arready_q    <= 1'b0;
            bvalid_q     <= 1'b0;
            bresp_q      <= RESP_OKAY;
            rvalid_q     <= 1'b0;
            rresp_q      <= RESP_OKAY;
            rdata_q      <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= '0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            wr_oor_q     <= 1'b0;
            rd_oor_q     <= 1'b0;
        end else begin
            mem_en_q  <= 1'b0;
            mem_we_q  <= '0;
            awready_q <= ~aw_full_d;
            wready_q  <= ~w_full_d;
            arready_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant_wr) begin
                        state_q      <= S_WR;
                        last_grant_q <= GNT_WRITE;
                        wr_oor_q     <= eff_aw_oor;
                        mem_en_q     <= ~eff_aw_oor;
                        mem_we_q     <= eff_aw_oor ? '0 : eff_wstrb;
                        mem_addr_q   <= eff_awaddr[G_ADDRWIDTH+1:2];
                        mem_din_q    <= eff_wdata;
                    end else if (grant_rd) begin
                        state_q      <= S_RD;
                        last_grant_q <= GNT_READ;
                        rd_oor_q     <= eff_ar_oor;
                        mem_en_q     <= ~eff_ar_oor;
                        mem_addr_q   <= eff_araddr[G_ADDRWIDTH+1:2];
                    end else begin
                        arready_q <= ~ar_full_d;
                    end
                end
                S_WR: begin
                    state_q  <= S_WRESP;
                    bvalid_q <= 1'b1;
                    bresp_q  <= wr_oor_q ? RESP_SLVERR : RESP_OKAY;
                end
                S_WRESP: begin
                    if (s_axi_bready) begin
                        bvalid_q  <= 1'b0;
                        state_q   <= S_IDLE;
                        arready_q <= ~ar_full_d;
                    end
                end
                S_RD: state_q <= S_RWAIT;
                S_RWAIT: begin
                    // Memory output is registered, so the word is valid one cycle after mem_en.
                    rdata_q  <= rd_oor_q ? '0 : mem_dout;
                    rresp_q  <= rd_oor_q ? RESP_SLVERR : RESP_OKAY;
                    rvalid_q <= 1'b1;
                    state_q  <= S_RRESP;
                end
                S_RRESP: begin
                    if (s_axi_rready) begin
                        rvalid_q  <= 1'b0;
                        state_q   <= S_IDLE;
                        arready_q <= ~ar_full_d;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_arready = arready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;
    assign mem_en        = mem_en_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_din       = mem_din_q;

endmodule
